// File: rtl/da_driver_pkg.sv
// Shared constants for the tx DAC driver and the rx ADC driver.
package da_driver_pkg;

    localparam int         DATA_W_DEF    = 8;
    localparam int         CNT_W_DEF     = 4;
    localparam int         FIFO_AW_DEF   = 2;
    localparam logic [7:0] IDLE_CODE_DEF = 8'h80;  // mid-scale

    // Converter clock phases for the default counter width: the sample clock
    // rises at the end of the first half-period, falls at the end of the
    // second, and the data word changes early in the low half.
    localparam int CLK_RISE_PH = (1 << (CNT_W_DEF - 1)) - 1;
    localparam int CLK_FALL_PH = (1 << CNT_W_DEF) - 1;
    localparam int UPD_PH      = 2;

endpackage

// File: rtl/da_driver_sync_fifo.sv
// Small synchronous FIFO with a first-word fall-through head.
module sync_fifo
    import da_driver_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int FIFO_AW = FIFO_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [DATA_W-1:0]  din,
    output logic [DATA_W-1:0]  dout,
    output logic [FIFO_AW:0]   level,
    output logic               full,
    output logic               empty
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = {1'b1, {FIFO_AW{1'b0}}};

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               do_push, do_pop;

    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // Qualify requests and compute next pointers and occupancy.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; the level counter alone decides what is valid.
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/da_driver.sv
// Tx DAC driver: buffers modulator samples and presents one per divided
// DAC clock period, stable around the DAC's rising sample edge.
module da_driver
    import da_driver_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                CNT_W     = CNT_W_DEF,
    parameter int                FIFO_AW   = FIFO_AW_DEF,
    parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(IDLE_CODE_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DATA_W-1:0]  din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic               dac_clk,
    output logic [DATA_W-1:0]  dac_data,
    output logic               dout_strobe,
    output logic               underrun,
    input  logic               underrun_clr,
    output logic [FIFO_AW:0]   fifo_level
);

    // Shared phase constants cover the default width; other widths use the
    // same half-period / full-period rule.
    localparam int RISE_I = (CNT_W == CNT_W_DEF) ? CLK_RISE_PH : (1 << (CNT_W - 1)) - 1;
    localparam int FALL_I = (CNT_W == CNT_W_DEF) ? CLK_FALL_PH : (1 << CNT_W) - 1;

    localparam logic [CNT_W-1:0] RISE_PH = CNT_W'(RISE_I);
    localparam logic [CNT_W-1:0] FALL_PH = CNT_W'(FALL_I);
    localparam logic [CNT_W-1:0] UPD_P   = CNT_W'(UPD_PH);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dac_clk_q, dac_clk_d;
    logic [DATA_W-1:0] dac_data_q, dac_data_d;
    logic              strobe_q, strobe_d;
    logic              underrun_q, underrun_d;

    logic              upd;
    logic              fifo_push, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    sync_fifo #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (din),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Phase counter, DAC clock, sample update and sticky underrun next-state.
    always_comb begin
        upd        = en && (cnt_q == UPD_P);
        fifo_push  = din_valid && !fifo_full;
        fifo_pop   = upd && !fifo_empty;

        cnt_d      = en ? cnt_q + 1'b1 : '0;

        dac_clk_d  = dac_clk_q;
        if (!en)                    dac_clk_d = 1'b0;
        else if (cnt_q == RISE_PH)  dac_clk_d = 1'b1;
        else if (cnt_q == FALL_PH)  dac_clk_d = 1'b0;

        // An update with nothing buffered drives mid-scale instead of stale data.
        dac_data_d = dac_data_q;
        if (upd) dac_data_d = fifo_empty ? IDLE_CODE : fifo_dout;
        strobe_d   = upd;

        // Set has priority over a clear on the same edge.
        underrun_d = underrun_q;
        if (underrun_clr)       underrun_d = 1'b0;
        if (upd && fifo_empty)  underrun_d = 1'b1;
    end

    // Output and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            dac_clk_q  <= 1'b0;
            dac_data_q <= IDLE_CODE;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dac_clk_q  <= dac_clk_d;
            dac_data_q <= dac_data_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    assign din_ready   = !fifo_full;
    assign dac_clk     = dac_clk_q;
    assign dac_data    = dac_data_q;
    assign dout_strobe = strobe_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_da_driver.sv
// Scoreboard bench for da_driver: stimulus queues the expected word for
// each DAC update, a negedge monitor pops and compares on dout_strobe.
module tb_da_driver;

    logic       clk = 1'b0;
    logic       rst, en, din_valid, underrun_clr;
    logic [7:0] din;
    logic       din_ready, dac_clk, dout_strobe, underrun;
    logic [7:0] dac_data;
    logic [2:0] fifo_level;

    always #5 clk = ~clk;

    da_driver dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .dac_clk      (dac_clk),
        .dac_data     (dac_data),
        .dout_strobe  (dout_strobe),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .fifo_level   (fifo_level)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       urun;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         ph     = 0;        // bench view of the phase counter
    logic [7:0] model_data = 8'h80; // word expected on dac_data between updates

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_upd(input logic [7:0] data, input logic urun);
        exp_q.push_back({data, urun});
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (dout_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got dac_data %0h with empty scoreboard at %0t", dac_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("upd_dac_data", dac_data, mon_e.data);
                check("upd_underrun", underrun, mon_e.urun);
                model_data = mon_e.data;
            end
        end
    end

    // One clock; checks sample clock shape, strobe timing and data stability.
    task automatic step(output bit upd);
        upd = !rst && en && (ph == 2);
        @(posedge clk);
        ph = (rst || !en) ? 0 : (ph + 1) % 16;
        #1;
        check("dac_clk", dac_clk, (ph >= 8) ? 1 : 0);
        check("dout_strobe", dout_strobe, upd);
        if (ph == 7 || ph == 8) check("dac_data_stable", dac_data, model_data);
    endtask

    task automatic run_updates(input int n);
        bit u;
        int seen = 0;
        for (int i = 0; i < 16 * n + 16 && seen < n; i++) begin
            step(u);
            if (u) seen++;
        end
    endtask

    task automatic advance_to_ph(input int target);
        bit u;
        for (int i = 0; i < 17 && ph != target; i++) step(u);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit u;
        logic [7:0] burst [3];
        logic [7:0] fill  [4];
        burst = '{8'h11, 8'h22, 8'h33};
        fill  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

        rst = 1'b1; en = 1'b0; din = '0; din_valid = 1'b0; underrun_clr = 1'b0;
        step(u);
        step(u);
        check("rst_dac_clk",    dac_clk,     0);
        check("rst_dac_data",   dac_data,    8'h80);
        check("rst_strobe",     dout_strobe, 0);
        check("rst_underrun",   underrun,    0);
        check("rst_fifo_level", fifo_level,  0);
        check("rst_din_ready",  din_ready,   1);

        // Idle run: mid-scale on every update, underrun from the first one.
        rst = 1'b0; en = 1'b1;
        repeat (3) expect_upd(8'h80, 1'b1);
        run_updates(3);
        underrun_clr = 1'b1;
        step(u);
        underrun_clr = 1'b0;
        check("clr_no_event", underrun, 0);

        // Back-to-back burst drains one per period, then underruns.
        din_valid = 1'b1;
        foreach (burst[i]) begin
            din = burst[i];
            check("burst_ready", din_ready, 1);
            step(u);
        end
        din_valid = 1'b0;
        check("burst_level", fifo_level, 3);
        expect_upd(8'h11, 1'b0);
        expect_upd(8'h22, 1'b0);
        expect_upd(8'h33, 1'b0);
        expect_upd(8'h80, 1'b1);
        run_updates(4);
        check("burst_drained", fifo_level, 0);

        // Fill while disabled: exactly four accepted, fifth refused.
        en = 1'b0;
        step(u);
        din_valid = 1'b1;
        foreach (fill[i]) begin
            din = fill[i];
            check("fill_ready", din_ready, 1);
            step(u);
        end
        din = 8'hA5;
        check("full_level", fifo_level, 4);
        check("full_ready", din_ready, 0);
        step(u);
        step(u);
        check("full_no_overwrite", fifo_level, 4);
        din_valid = 1'b0;
        foreach (fill[i]) expect_upd(fill[i], 1'b1);
        en = 1'b1;
        run_updates(1);
        check("ready_after_pop", din_ready, 1);
        check("level_after_pop", fifo_level, 3);
        run_updates(3);
        check("fill_drained", fifo_level, 0);

        // Push on the update edge into an empty FIFO, with a same-edge clear.
        underrun_clr = 1'b1;
        step(u);
        underrun_clr = 1'b0;
        check("clr_before_align", underrun, 0);
        advance_to_ph(2);
        expect_upd(8'h80, 1'b1);
        expect_upd(8'h5A, 1'b1);
        din = 8'h5A; din_valid = 1'b1; underrun_clr = 1'b1;
        step(u);
        din_valid = 1'b0; underrun_clr = 1'b0;
        check("align_level", fifo_level, 1);
        run_updates(1);
        check("align_drained", fifo_level, 0);

        // Reset mid-operation with samples buffered and dac_clk high.
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 8'hC1 + 8'(i);
            step(u);
        end
        din_valid = 1'b0;
        advance_to_ph(8);
        check("pre_rst_dac_clk", dac_clk, 1);
        check("pre_rst_level", fifo_level, 3);
        rst = 1'b1;
        step(u);
        check("mid_rst_dac_clk",  dac_clk,    0);
        check("mid_rst_dac_data", dac_data,   8'h80);
        check("mid_rst_level",    fifo_level, 0);
        check("mid_rst_underrun", underrun,   0);
        check("mid_rst_ready",    din_ready,  1);
        rst = 1'b0;
        model_data = 8'h80;
        expect_upd(8'h80, 1'b1);
        run_updates(1);
        repeat (3) step(u);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/da_driver.md
Name: da_driver

Overview:
- Transmit-side converter driver: the mirror of the receive-path ADC driver.
- Accepts parallel samples from the modulator over a valid/ready handshake and buffers them in a small FIFO.
- Generates a divided DAC sample clock and presents one sample per DAC clock period, stable around the DAC's rising sample edge.
- Sits between the tx modulator and the external 8-bit DAC pins.

Parameters:
- DATA_W, 8, sample width in bits.
- CNT_W, 4, phase counter width; DAC clock period = 2^CNT_W clk cycles.
- FIFO_AW, 2, FIFO address width; depth = 2^FIFO_AW = 4.
- IDLE_CODE, 8'h80, value driven on underrun and after reset (mid-scale).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable for the DAC clock and data update
- din  in  DATA_W  sample from modulator
- din_valid  in  1  din is valid
- din_ready  out  1  FIFO can accept; transfer occurs when din_valid && din_ready at posedge clk
- dac_clk  out  1  divided sample clock to DAC, registered
- dac_data  out  DATA_W  sample to DAC, registered
- dout_strobe  out  1  one-cycle pulse coincident with each dac_data update
- underrun  out  1  sticky flag: an update found the FIFO empty
- underrun_clr  in  1  clears underrun
- fifo_level  out  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW

Behaviour:
Reset (rst=1 at posedge clk):
- cnt=0, dac_clk=0, dac_data=IDLE_CODE, dout_strobe=0, underrun=0.
- FIFO emptied: fifo_level=0, din_ready=1.
- Reset mid-operation discards buffered samples.

Phase counter:
- When en=1, cnt increments by 1 each clk and wraps from 2^CNT_W-1 to 0.
- When en=0, cnt is held at 0 and dac_clk is forced 0 on the next edge; dac_data holds its value.

DAC clock (defaults shown):
- dac_clk <= 1 at the edge where cnt==7; dac_clk <= 0 at the edge where cnt==15.
- General form: rise at cnt==2^(CNT_W-1)-1, fall at cnt==2^CNT_W-1.
- Result: 50% duty, period 16 clk.

Data update:
- Occurs at the edge where cnt==2 and en=1.
- FIFO non-empty: dac_data <= FIFO head; head popped; dout_strobe=1 for that one cycle.
- FIFO empty: dac_data <= IDLE_CODE; underrun <= 1; dout_strobe=1.
- dac_data is therefore stable from 5 clk before the dac_clk rising edge until 11 clk after it.

FIFO:
- Synchronous, first-word fall-through head, depth 2^FIFO_AW.
- din_ready = (fifo_level != depth).
- Push and pop on the same edge: both happen; level unchanged.
- Full: din_ready=0, din is ignored; no overwrite.
- Push into an empty FIFO on the same edge as an update: the update sees empty, so IDLE_CODE is driven and underrun is set; the pushed sample is output at the next update.

Underrun flag:
- Set by an underrun event, cleared by underrun_clr.
- Set and clear on the same edge: set wins.

Latency:
- A sample accepted into an empty FIFO appears on dac_data at the next update edge, 1..16 clk later.
- Sustained throughput: one sample per 16 clk.

Decomposition:
- Shared package: DATA_W and IDLE_CODE defaults, and the DAC clock phase constants (CLK_RISE_PH, CLK_FALL_PH, UPD_PH), also used by the ADC driver.
- One sub-module: sync_fifo (parameters DATA_W and FIFO_AW; ports push, pop, din, dout, level, full, empty). Reusable by the rx path.

Test Plan:
- Reset then en=1 with no input -> dac_clk toggles with period 16 (high on cycles 8..15); dac_data=8'h80; underrun=1 after the first update; dout_strobe pulses every 16 clk.
- Push 8'h11, 8'h22, 8'h33 back-to-back with en=1 -> dac_data shows 11, 22, 33 on three consecutive updates at cnt==2; each is stable across the dac_clk rising edge; then 8'h80 with underrun=1.
- Hold din_valid=1 with en=0 -> exactly 4 samples accepted, then din_ready=0 and fifo_level=4; raise en -> samples drain in order and din_ready re-asserts after the first pop.
- Push aligned to the same edge as an update with the FIFO empty -> IDLE_CODE and underrun on this update; the pushed value appears 16 clk later.
- Assert rst with 3 samples buffered and dac_clk=1 -> next cycle dac_clk=0, dac_data=8'h80, fifo_level=0, underrun=0.
- Assert underrun_clr on the same cycle as an underrun event -> underrun remains 1; clr on a non-event cycle -> underrun goes 0.
